// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter merging several AXI-stream byte sources onto one
// UART TX byte stream, prefixing each packet with a one-byte source header (0xA0 | idx).
module uart_tx_arbiter #(
  parameter int NUM_SRC_P = 2,
  parameter int MAX_LEN_P = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [NUM_SRC_P-1:0]   src_valid_i,
  input  logic [8*NUM_SRC_P-1:0] src_data_i,
  input  logic [NUM_SRC_P-1:0]   src_last_i,
  output logic [NUM_SRC_P-1:0]   src_ready_o,
  input  logic                   hold_i,
  output logic                   m_valid_o,
  output logic [7:0]             m_data_o,
  output logic                   m_last_o,
  input  logic                   m_ready_i,
  output logic [NUM_SRC_P-1:0]   grant_o,
  output logic                   err_len_o
);

  localparam int          IDX_W    = $clog2(NUM_SRC_P);
  localparam logic [15:0] LAST_CNT = 16'(MAX_LEN_P - 1);

  typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             err_len_q, err_len_d;

  logic [7:0]       src_byte [NUM_SRC_P];
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             load;
  logic             at_max;

  always_comb begin
    for (int k = 0; k < NUM_SRC_P; k++) begin
      src_byte[k] = src_data_i[8*k +: 8];
    end
  end

  // Search starts just after the last winner, so a source that just finished
  // ranks lowest for the next grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_SRC_P; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_SRC_P);
      if (!win_found && src_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    load        = !m_valid_q || m_ready_i;
    at_max      = (cnt_q == LAST_CNT);
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    m_valid_d   = load ? 1'b0 : m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    err_len_d   = 1'b0;
    src_ready_o = '0;
    unique case (state_q)
      S_IDLE: begin
        // Selecting a source only emits the header; its first byte is taken later.
        if (win_found && load && !hold_i) begin
          state_d   = S_PAYLOAD;
          ptr_d     = win_idx;
          cnt_d     = '0;
          m_valid_d = 1'b1;
          m_data_d  = 8'hA0 | 8'(win_idx);
          m_last_d  = 1'b0;
        end
      end
      S_PAYLOAD: begin
        src_ready_o[ptr_q] = load && !hold_i;
        if (load && !hold_i && src_valid_i[ptr_q]) begin
          cnt_d     = cnt_q + 16'd1;
          m_valid_d = 1'b1;
          m_data_d  = src_byte[ptr_q];
          m_last_d  = src_last_i[ptr_q] || at_max;
          if (m_last_d) begin
            state_d   = S_IDLE;
            err_len_d = !src_last_i[ptr_q] && at_max;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDX_W'(NUM_SRC_P - 1);
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_len_q <= err_len_d;
    end
  end

  // While a packet is in flight the pointer doubles as the granted index.
  always_comb begin
    grant_o = '0;
    if (state_q == S_PAYLOAD) grant_o[ptr_q] = 1'b1;
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign err_len_o = err_len_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle reference model, per-source byte
// stream scoreboard, directed scenarios with literal expectations, then random traffic.
module tb_uart_tx_arbiter;
  localparam int N    = 2;
  localparam int MAXL = 4;
  localparam int BUFD = 4096;

  logic           clk = 1'b0;
  logic           reset_n_i;
  logic [N-1:0]   src_valid_i, src_last_i, src_ready_o, grant_o;
  logic [8*N-1:0] src_data_i;
  logic           hold_i, m_valid_o, m_last_o, m_ready_i, err_len_o;
  logic [7:0]     m_data_o;

  uart_tx_arbiter #(.NUM_SRC_P(N), .MAX_LEN_P(MAXL)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_last_i(src_last_i),
    .src_ready_o(src_ready_o), .hold_i(hold_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i), .grant_o(grant_o), .err_len_o(err_len_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Source byte buffers: {last, data}; written by the driver only.
  logic [8:0] srcbuf [N][BUFD];
  int s_wr [N];
  int s_rd [N];

  // Reference model state and observation logs; written by the compare process only.
  logic       mv, ml, merr, ld_m;
  logic [7:0] md;
  bit         busy;
  int         owner, sent, lastw, w;
  int         cyc = 0;
  logic [N-1:0] hs_seen;
  bit         stall_prev;
  logic [7:0] stall_d;
  bit         in_pkt;
  int         pkt_src;
  int         strm_rd [N];
  logic [8:0] acc_log [8192];
  int         acc_cyc [8192];
  int         acc_n = 0;
  int         err_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n_i) begin
      mv = 1'b0; md = '0; ml = 1'b0; merr = 1'b0;
      busy = 0; owner = 0; sent = 0; lastw = N - 1;
      hs_seen = '0; stall_prev = 0; in_pkt = 0; pkt_src = 0;
      for (int s = 0; s < N; s++) strm_rd[s] = s_wr[s];
    end else begin
      cyc++;
      ld_m = !mv || m_ready_i;
      chk("m_valid", m_valid_o, mv);
      if (mv) begin
        chk("m_data", m_data_o, md);
        chk("m_last", m_last_o, ml);
      end
      chk("err_len", err_len_o, merr);
      chk("grant", grant_o, busy ? (1 << owner) : 0);
      chk("src_ready", src_ready_o, (busy && ld_m && !hold_i) ? (1 << owner) : 0);
      if (stall_prev) chk("stall_stable", {m_valid_o, m_data_o}, {1'b1, stall_d});
      stall_prev = m_valid_o && !m_ready_i;
      stall_d    = m_data_o;
      if (err_len_o) err_cnt++;
      hs_seen = src_valid_i & src_ready_o;

      if (m_valid_o && m_ready_i) begin
        acc_log[acc_n] = {m_last_o, m_data_o};
        acc_cyc[acc_n] = cyc;
        acc_n++;
        if (!in_pkt) begin
          chk("hdr_tag", m_data_o[7:4], 4'hA);
          in_pkt  = 1;
          pkt_src = int'(m_data_o[3:0]);
          if (pkt_src >= N) pkt_src = 0;
        end else begin
          chk("stream_byte", m_data_o, srcbuf[pkt_src][strm_rd[pkt_src] % BUFD][7:0]);
          strm_rd[pkt_src]++;
          if (m_last_o) in_pkt = 0;
        end
      end

      // Predict the effect of the coming edge.
      merr = 1'b0;
      if (ld_m) mv = 1'b0;
      if (!busy) begin
        if (src_valid_i != '0 && ld_m && !hold_i) begin
          w = -1;
          for (int i = 1; i <= N; i++)
            if (w < 0 && src_valid_i[(lastw + i) % N]) w = (lastw + i) % N;
          busy = 1; owner = w; lastw = w; sent = 0;
          mv = 1'b1; md = 8'hA0 | 8'(w); ml = 1'b0;
        end
      end else if (ld_m && !hold_i && src_valid_i[owner]) begin
        sent++;
        mv = 1'b1;
        md = src_data_i[8*owner +: 8];
        ml = src_last_i[owner] || (sent == MAXL);
        if (ml) begin
          busy = 0;
          merr = !src_last_i[owner] && (sent == MAXL);
        end
      end
    end
  end

  // Driver
  logic [N-1:0] cur_v;
  int  vprob = 100, rprob = 100, hprob = 0;
  bit  gen_on = 0, rtoggle = 0, tog = 1;

  task automatic push_byte(input int s, input logic [7:0] d, input logic l);
    srcbuf[s][s_wr[s] % BUFD] = {l, d};
    s_wr[s]++;
  endtask

  task automatic step();
    int len;
    @(posedge clk);
    #2;
    for (int s = 0; s < N; s++) begin
      if (hs_seen[s]) begin s_rd[s]++; cur_v[s] = 1'b0; end
      if (gen_on && s_rd[s] == s_wr[s] && s_wr[s] < 3500 && $urandom_range(3) == 0) begin
        len = $urandom_range(7, 1);
        for (int b = 0; b < len; b++) push_byte(s, 8'($urandom), b == len - 1);
      end
      if (!cur_v[s] && s_rd[s] != s_wr[s] && $urandom_range(99) < vprob) cur_v[s] = 1'b1;
      src_data_i[8*s +: 8] = srcbuf[s][s_rd[s] % BUFD][7:0];
      src_last_i[s]        = srcbuf[s][s_rd[s] % BUFD][8];
    end
    src_valid_i = cur_v;
    if (rtoggle) begin m_ready_i = tog; tog = ~tog; end
    else m_ready_i = ($urandom_range(99) < rprob);
    hold_i = ($urandom_range(99) < hprob);
  endtask

  function automatic bit drained();
    bit d = (cur_v == '0) && !busy && !mv;
    for (int s = 0; s < N; s++) if (s_rd[s] != s_wr[s]) d = 0;
    return d;
  endfunction

  task automatic run_idle(input string nm, input int maxc);
    int c = 0;
    do begin step(); c++; end while (!drained() && c < maxc);
    chk({nm, "_drained"}, drained(), 1'b1);
  endtask

  task automatic chk_log(input string nm, input int base, input logic [8:0] exp [], input int n);
    chk({nm, "_count"}, acc_n - base, n);
    for (int i = 0; i < n; i++) chk(nm, acc_log[base + i], exp[i]);
  endtask

  int base, ebase, cnt_r;
  logic [8:0] e [];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0; src_valid_i = '0; src_data_i = '0; src_last_i = '0;
    hold_i = 1'b0; m_ready_i = 1'b0; cur_v = '0;
    for (int s = 0; s < N; s++) begin s_wr[s] = 0; s_rd[s] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid_o, 0);   chk("rst_m_data", m_data_o, 0);
    chk("rst_m_last", m_last_o, 0);     chk("rst_grant", grant_o, 0);
    chk("rst_src_ready", src_ready_o, 0); chk("rst_err_len", err_len_o, 0);
    #2 reset_n_i = 1'b1;

    // Fairness: both sources hold two 2-byte packets.
    push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 1); push_byte(0, 8'h03, 0); push_byte(0, 8'h04, 1);
    push_byte(1, 8'h11, 0); push_byte(1, 8'h12, 1); push_byte(1, 8'h13, 0); push_byte(1, 8'h14, 1);
    base = acc_n;
    run_idle("fair", 100);
    e = '{9'h0A0, 9'h001, 9'h102, 9'h0A1, 9'h011, 9'h112, 9'h0A0, 9'h003, 9'h104, 9'h0A1, 9'h013, 9'h114};
    chk_log("fair_seq", base, e, 12);
    chk("fair_no_gap", acc_cyc[base + 11] - acc_cyc[base], 11);

    // Single packet from source 1.
    push_byte(1, 8'h11, 0); push_byte(1, 8'h22, 0); push_byte(1, 8'h33, 1);
    base = acc_n;
    run_idle("single", 50);
    e = '{9'h0A1, 9'h011, 9'h022, 9'h133};
    chk_log("single_seq", base, e, 4);

    // Backpressure with toggling downstream ready.
    rtoggle = 1;
    push_byte(0, 8'h61, 0); push_byte(0, 8'h62, 0); push_byte(0, 8'h63, 1);
    base = acc_n;
    run_idle("bp", 50);
    rtoggle = 0;
    e = '{9'h0A0, 9'h061, 9'h062, 9'h163};
    chk_log("bp_seq", base, e, 4);

    // Truncation at MAX_LEN_P = 4.
    for (int i = 1; i <= 6; i++) push_byte(0, 8'(i), i == 6);
    base = acc_n; ebase = err_cnt;
    run_idle("trunc", 60);
    e = '{9'h0A0, 9'h001, 9'h002, 9'h003, 9'h104, 9'h0A0, 9'h005, 9'h106};
    chk_log("trunc_seq", base, e, 8);
    chk("trunc_err_pulses", err_cnt - ebase, 1);

    // Hold mid-packet, then hold while idle with a request pending.
    base = acc_n;
    push_byte(0, 8'h51, 0); push_byte(0, 8'h52, 0); push_byte(0, 8'h53, 0); push_byte(0, 8'h54, 1);
    step(); step();
    hprob = 100; cnt_r = 0;
    repeat (5) begin step(); #1; if (src_ready_o != '0) cnt_r++; end
    chk("hold_ready_zero", cnt_r, 0);
    hprob = 0;
    run_idle("hold_pkt", 50);
    hprob = 100; cnt_r = 0;
    push_byte(1, 8'h71, 1);
    repeat (5) begin step(); #1; if (grant_o != '0) cnt_r++; end
    chk("hold_no_grant", cnt_r, 0);
    hprob = 0;
    run_idle("hold_idle", 50);
    e = '{9'h0A0, 9'h051, 9'h052, 9'h053, 9'h154, 9'h0A1, 9'h171};
    chk_log("hold_seq", base, e, 7);

    // Random traffic.
    gen_on = 1; vprob = 70; rprob = 75; hprob = 10;
    repeat (3000) step();
    gen_on = 0;
    run_idle("random", 3000);
    vprob = 100; rprob = 100; hprob = 0;

    // Asynchronous reset in the middle of a payload.
    for (int i = 0; i < 8; i++) push_byte(1, 8'h80 + 8'(i), i == 7);
    push_byte(0, 8'h90, 1);
    step(); step(); step(); step();
    #1 reset_n_i = 1'b0;
    #1;
    chk("arst_m_valid", m_valid_o, 0);   chk("arst_m_data", m_data_o, 0);
    chk("arst_m_last", m_last_o, 0);     chk("arst_grant", grant_o, 0);
    chk("arst_src_ready", src_ready_o, 0); chk("arst_err_len", err_len_o, 0);
    cur_v = '0; src_valid_i = '0;
    for (int s = 0; s < N; s++) s_rd[s] = s_wr[s];
    @(posedge clk); @(posedge clk);
    #3 reset_n_i = 1'b1;
    push_byte(1, 8'h91, 1); push_byte(0, 8'h92, 1);
    base = acc_n;
    run_idle("post_rst", 50);
    e = '{9'h0A0, 9'h192, 9'h0A1, 9'h191};
    chk_log("post_rst_seq", base, e, 4);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
